// File: rtl/fnd_scan_capture.sv
// Recovers 4-bit digit codes from a multiplexed active-low 7-segment bus and commits coherent 16-bit frames.
// Optional FND_DP_STRIP_EN: accept digit fonts with a lit dp and report per-digit dp flags on o_dp.
module fnd_scan_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_font,
  input  logic [3:0]  i_digit_sel,
  output logic [15:0] o_bcd_value,
  output logic        o_frame_valid,
  output logic [3:0]  o_dp,
  output logic        o_decode_err
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       prev_sel_q;
  logic [7:0]       prev_font_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             captured_q, captured_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       mask_q, mask_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             frame_valid_q, frame_valid_d;
  logic             decode_err_q, decode_err_d;
`ifdef FND_DP_STRIP_EN
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       dp_q, dp_d;
  logic             dec_dp;
  logic [4:0]       dec_strip;
`endif

  logic             sel_valid;
  logic [1:0]       sel_idx;
  logic             dec_ok;
  logic [3:0]       dec_code;
  logic [4:0]       dec_plain;
  logic             pair_match;
  logic             capture;

  // Returns {hit, code} for the ten numeric glyphs only.
  function automatic logic [4:0] digit_lookup(input logic [7:0] f);
    logic [4:0] r;
    r = 5'b0_0000;
    case (f)
      8'hC0: r = 5'h10;
      8'hF9: r = 5'h11;
      8'hA4: r = 5'h12;
      8'hB0: r = 5'h13;
      8'h99: r = 5'h14;
      8'h92: r = 5'h15;
      8'h82: r = 5'h16;
      8'hF8: r = 5'h17;
      8'h80: r = 5'h18;
      8'h90: r = 5'h19;
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    case (i_digit_sel)
      4'b1110: begin sel_valid = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_valid = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_valid = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_valid = 1'b1; sel_idx = 2'd3; end
      default: begin sel_valid = 1'b0; sel_idx = 2'd0; end
    endcase
  end

  always_comb begin
    dec_ok    = 1'b0;
    dec_code  = 4'hB;
    dec_plain = digit_lookup(i_font);
`ifdef FND_DP_STRIP_EN
    dec_dp    = 1'b0;
    dec_strip = digit_lookup(i_font | 8'h80);
`endif
    if (i_font == 8'h7F) begin
      dec_ok   = 1'b1;
      dec_code = 4'hA;
    end else if (i_font == 8'hFF) begin
      dec_ok   = 1'b1;
      dec_code = 4'hB;
    end else if (dec_plain[4]) begin
      dec_ok   = 1'b1;
      dec_code = dec_plain[3:0];
    end
`ifdef FND_DP_STRIP_EN
    // A numeric glyph with the dp segment lit: strip dp and remember it.
    else if (!i_font[7] && dec_strip[4]) begin
      dec_ok   = 1'b1;
      dec_code = dec_strip[3:0];
      dec_dp   = 1'b1;
    end
`endif
  end

  always_comb begin
    cnt_d         = cnt_q;
    captured_d    = captured_q;
    shadow_d      = shadow_q;
    mask_d        = mask_q;
    bcd_d         = bcd_q;
    frame_valid_d = 1'b0;
    decode_err_d  = 1'b0;
`ifdef FND_DP_STRIP_EN
    shadow_dp_d   = shadow_dp_q;
    dp_d          = dp_q;
`endif
    pair_match = (i_digit_sel == prev_sel_q) && (i_font == prev_font_q);
    capture    = 1'b0;

    if (pair_match && sel_valid) begin
      capture = (cnt_q == CNT_MAX) && !captured_q;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (capture) captured_d = 1'b1;
    end else begin
      cnt_d      = '0;
      captured_d = 1'b0;
    end

    // Undecodable glyphs still consume the dwell so the error fires once.
    if (capture) begin
      if (dec_ok) begin
        shadow_d[{sel_idx, 2'b00} +: 4] = dec_code;
        mask_d[sel_idx]                 = 1'b1;
`ifdef FND_DP_STRIP_EN
        shadow_dp_d[sel_idx]            = dec_dp;
`endif
        if (mask_d == 4'hF) begin
          bcd_d         = shadow_d;
          frame_valid_d = 1'b1;
          mask_d        = 4'h0;
`ifdef FND_DP_STRIP_EN
          dp_d          = shadow_dp_d;
`endif
        end
      end else begin
        decode_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_sel_q    <= 4'hF;
      prev_font_q   <= 8'hFF;
      cnt_q         <= '0;
      captured_q    <= 1'b0;
      shadow_q      <= 16'hBBBB;
      mask_q        <= 4'h0;
      bcd_q         <= 16'hBBBB;
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
`ifdef FND_DP_STRIP_EN
      shadow_dp_q   <= 4'h0;
      dp_q          <= 4'h0;
`endif
    end else begin
      prev_sel_q    <= i_digit_sel;
      prev_font_q   <= i_font;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      bcd_q         <= bcd_d;
      frame_valid_q <= frame_valid_d;
      decode_err_q  <= decode_err_d;
`ifdef FND_DP_STRIP_EN
      shadow_dp_q   <= shadow_dp_d;
      dp_q          <= dp_d;
`endif
    end
  end

  assign o_bcd_value   = bcd_q;
  assign o_frame_valid = frame_valid_q;
  assign o_decode_err  = decode_err_q;
`ifdef FND_DP_STRIP_EN
  assign o_dp          = dp_q;
`else
  assign o_dp          = 4'h0;
`endif

endmodule

// File: tb/tb_fnd_scan_capture.sv
// Self-checking bench for fnd_scan_capture: run-length behavioural model plus directed scan scenarios.
// Honours FND_DP_STRIP_EN in both the model and the literal expectations.
module tb_fnd_scan_capture;

  localparam int STABLE = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  font;
  logic [3:0]  sel;
  logic [15:0] bcd_value;
  logic        frame_valid;
  logic [3:0]  dp;
  logic        decode_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int err_cnt  = 0;

  fnd_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_font        (font),
    .i_digit_sel   (sel),
    .o_bcd_value   (bcd_value),
    .o_frame_valid (frame_valid),
    .o_dp          (dp),
    .o_decode_err  (decode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic [3:0]  m_lsel;
  logic [7:0]  m_lfont;
  bit          m_have;
  int          m_run;
  logic [3:0]  m_shadow [4];
  logic        m_sdp [4];
  bit          m_mask [4];
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic        m_fv;
  logic        m_err;

  function automatic bit model_decode(input logic [7:0] f, output logic [3:0] code,
                                      output logic with_dp);
    code    = 4'hB;
    with_dp = 1'b0;
    if (f == 8'h7F) begin code = 4'hA; return 1'b1; end
    if (f == 8'hFF) begin code = 4'hB; return 1'b1; end
    for (int k = 0; k < 10; k++)
      if (glyph[k] == f) begin code = 4'(k); return 1'b1; end
`ifdef FND_DP_STRIP_EN
    if (!f[7])
      for (int k = 0; k < 10; k++)
        if (glyph[k] == (f | 8'h80)) begin code = 4'(k); with_dp = 1'b1; return 1'b1; end
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_have = 1'b0;
    m_run  = 0;
    for (int k = 0; k < 4; k++) begin
      m_shadow[k] = 4'hB;
      m_sdp[k]    = 1'b0;
      m_mask[k]   = 1'b0;
    end
    m_bcd = 16'hBBBB;
    m_dp  = 4'h0;
    m_fv  = 1'b0;
    m_err = 1'b0;
  endtask

  // A digit is captured when the same valid pair has been sampled on STABLE+1 consecutive edges.
  task automatic model_step();
    logic [3:0] code;
    logic       wdp;
    int         idx;
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (m_have && sel == m_lsel && font == m_lfont) m_run++;
    else m_run = 1;
    m_have  = 1'b1;
    m_lsel  = sel;
    m_lfont = font;
    if ($countones(~sel) == 1 && m_run == STABLE + 1) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (!sel[k]) idx = k;
      if (model_decode(font, code, wdp)) begin
        m_shadow[idx] = code;
        m_sdp[idx]    = wdp;
        m_mask[idx]   = 1'b1;
        if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) begin
          m_bcd = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
          m_dp  = {m_sdp[3], m_sdp[2], m_sdp[1], m_sdp[0]};
          m_fv  = 1'b1;
          for (int k = 0; k < 4; k++) m_mask[k] = 1'b0;
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("bcd_vs_model", bcd_value, m_bcd);
      check("frame_valid_vs_model", {15'd0, frame_valid}, {15'd0, m_fv});
      check("decode_err_vs_model", {15'd0, decode_err}, {15'd0, m_err});
      check("dp_vs_model", {12'd0, dp}, {12'd0, m_dp});
      if (frame_valid === 1'b1) fv_cnt++;
      if (decode_err === 1'b1) err_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic dwell(input logic [3:0] s, input logic [7:0] f, input int n);
    @(negedge clk);
    sel  = s;
    font = f;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan4(input logic [7:0] f0, input logic [7:0] f1,
                       input logic [7:0] f2, input logic [7:0] f3);
    dwell(4'hE, f0, 20);
    dwell(4'hD, f1, 20);
    dwell(4'hB, f2, 20);
    dwell(4'h7, f3, 20);
  endtask

  initial begin
    sel   = 4'hF;
    font  = 8'hFF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bcd", bcd_value, 16'hBBBB);
    check("reset_fv", {15'd0, frame_valid}, 16'h0000);
    check("reset_err", {15'd0, decode_err}, 16'h0000);
    check("reset_dp", {12'd0, dp}, 16'h0000);
    rst_n = 1'b1;

    // Idle bus
    dwell(4'hF, 8'hFF, 50);
    check("idle_bcd", bcd_value, 16'hBBBB);
    check("idle_fv_count", 16'(fv_cnt), 16'd0);
    check("idle_err_count", 16'(err_cnt), 16'd0);

    // Full scan 2,1,0,4
    scan4(8'hA4, 8'hF9, 8'hC0, 8'h99);
    dwell(4'hF, 8'hFF, 5);
    check("scan_fv_count", 16'(fv_cnt), 16'd1);
    check("scan_bcd", bcd_value, 16'h4012);

    // Abandoned digit-0 dwell: slot 0 must not be captured
    dwell(4'hE, 8'h92, 3);
    dwell(4'hD, 8'hF9, 20);
    dwell(4'hB, 8'hC0, 20);
    dwell(4'h7, 8'h99, 20);
    dwell(4'hF, 8'hFF, 5);
    check("short_no_commit", 16'(fv_cnt), 16'd1);
    check("short_bcd_held", bcd_value, 16'h4012);
    dwell(4'hE, 8'h92, 20);
    dwell(4'hF, 8'hFF, 5);
    check("short_then_full_fv", 16'(fv_cnt), 16'd2);
    check("short_then_full_bcd", bcd_value, 16'h4015);

    // Undecodable glyph on digit 1
    dwell(4'hD, 8'h55, 20);
    dwell(4'hF, 8'hFF, 5);
    check("bad_font_err_count", 16'(err_cnt), 16'd1);
    check("bad_font_no_commit", 16'(fv_cnt), 16'd2);

    // Reset after three of four digits, then a fresh full scan
    dwell(4'hE, 8'h90, 20);
    dwell(4'hD, 8'h90, 20);
    dwell(4'hB, 8'h90, 20);
    @(negedge clk);
    rst_n = 1'b0;
    sel   = 4'hF;
    font  = 8'hFF;
    @(negedge clk);
    check("midreset_bcd", bcd_value, 16'hBBBB);
    check("midreset_fv", {15'd0, frame_valid}, 16'h0000);
    rst_n = 1'b1;
    dwell(4'hF, 8'hFF, 3);
    scan4(8'h90, 8'h90, 8'h90, 8'h90);
    dwell(4'hF, 8'hFF, 5);
    check("after_reset_fv_count", 16'(fv_cnt), 16'd3);
    check("after_reset_bcd", bcd_value, 16'h9999);

    // Digit 2 shows 6 with dp lit, others 7
    scan4(8'hF8, 8'hF8, 8'h02, 8'hF8);
    dwell(4'hF, 8'hFF, 5);
`ifdef FND_DP_STRIP_EN
    check("dp_fv_count", 16'(fv_cnt), 16'd4);
    check("dp_bcd", bcd_value, 16'h7677);
    check("dp_flags", {12'd0, dp}, 16'h0004);
    check("dp_err_count", 16'(err_cnt), 16'd1);
`else
    check("nodp_err_count", 16'(err_cnt), 16'd2);
    check("nodp_no_commit", 16'(fv_cnt), 16'd3);
    check("nodp_bcd_held", bcd_value, 16'h9999);
    check("nodp_dp_zero", {12'd0, dp}, 16'h0000);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
